stoch_vec_decoder: RTL and testbench

- Converts a vector of bipolar stochastic bitstreams into signed binary estimates. It is the decode end for the bitstreams our stochastic datapath emits (e.g. dot-product outputs).
- Each lane carries a positive stream and a negative stream. The block counts (ones on positive) minus (ones on negative) over a fixed window of 2^WIN_LOG2 cycles.
- The per-lane results are presented through a valid/ready handshake to binary consumers such as the host readout and the training loop.

---
 rtl/stoch_vec_decoder.sv | 183 ++++++++++++++++++
 tb/tb_stoch_vec_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_vec_decoder.sv
// stoch_vec_decoder: decodes a vector of bipolar stochastic bitstreams into
// signed binary estimates, counting ones(x_p) - ones(x_m) per lane over a
// window of 2^WIN_LOG2 sample cycles. Results leave through valid/ready.
// Optional feature: define STOCH_VEC_DECODER_CONT_EN for free-running
// continuous mode, which adds the sticky 'overrun' output.

module stoch_vec_decoder_lane #(
    parameter int W = 10
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clr,
    input  logic                en,
    input  logic                x_p,
    input  logic                x_m,
    output logic signed [W-1:0] sum
);
    logic signed [W-1:0] acc_q, acc_d, inc;

    // Ternary increment from the stream pair and the next accumulator value
    always_comb begin
        inc = '0;
        if (x_p && !x_m)      inc = W'(1);
        else if (!x_p && x_m) inc = '1;
        sum   = acc_q + inc;
        acc_d = acc_q;
        if (clr)     acc_d = '0;
        else if (en) acc_d = sum;
    end

    // Accumulator register; clear wins over enable so a new window starts at 0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

module stoch_vec_decoder #(
    parameter int VEC_LEN  = 2,
    parameter int WIN_LOG2 = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             start,
    output logic                             busy,
    input  logic [VEC_LEN-1:0]               x_p,
    input  logic [VEC_LEN-1:0]               x_m,
    output logic [VEC_LEN*(WIN_LOG2+2)-1:0]  y,
    output logic                             y_valid,
    input  logic                             y_ready
`ifdef STOCH_VEC_DECODER_CONT_EN
    ,
    output logic                             overrun
`endif
);
    localparam int YW = WIN_LOG2 + 2;
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << WIN_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

`ifdef STOCH_VEC_DECODER_CONT_EN
    // Free-running: come out of reset already accumulating
    localparam state_t RST_STATE = ACCUM;
    logic unused_start;
    assign unused_start = start;
    logic overrun_q, overrun_d;
    assign overrun = overrun_q;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [VEC_LEN-1:0][YW-1:0] y_q, y_d, lane_sum;
    logic                       y_valid_q, y_valid_d;
    logic                       clr, en, last;

    // One accumulator per lane, all sharing the window control
    for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
        stoch_vec_decoder_lane #(.W(YW)) u_lane (
            .CLK (CLK),
            .RST (RST),
            .clr (clr),
            .en  (en),
            .x_p (x_p[i]),
            .x_m (x_m[i]),
            .sum (lane_sum[i])
        );
    end

    assign last    = (cnt_q == CNT_LAST);
    assign busy    = (state_q == ACCUM);
    assign y       = y_q;
    assign y_valid = y_valid_q;

    // Next-state, window control and result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        clr       = 1'b0;
        en        = 1'b0;
`ifdef STOCH_VEC_DECODER_CONT_EN
        overrun_d = overrun_q;
        // A completing window below re-raises valid, so an accept in the
        // same cycle consumes the old result only
        if (y_ready) y_valid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef STOCH_VEC_DECODER_CONT_EN
                clr     = 1'b1;
                cnt_d   = '0;
                state_d = ACCUM;
`else
                if (start) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
`endif
            end
            ACCUM: begin
                en    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    // Final sums include this cycle's increment
                    y_d       = lane_sum;
                    y_valid_d = 1'b1;
`ifdef STOCH_VEC_DECODER_CONT_EN
                    if (y_valid_q && !y_ready) overrun_d = 1'b1;
                    clr   = 1'b1;
                    cnt_d = '0;
`else
                    state_d = HOLD;
`endif
                end
            end
            HOLD: begin
`ifdef STOCH_VEC_DECODER_CONT_EN
                clr     = 1'b1;
                cnt_d   = '0;
                state_d = ACCUM;
`else
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    if (start) begin
                        clr     = 1'b1;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
`endif
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
`ifdef STOCH_VEC_DECODER_CONT_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
`ifdef STOCH_VEC_DECODER_CONT_EN
            overrun_q <= overrun_d;
`endif
        end
    end
endmodule

// File: tb/tb_stoch_vec_decoder.sv
// Randomized self-checking bench for stoch_vec_decoder (VEC_LEN=2, WIN_LOG2=4).
// Reference: each lane's expected result is ones(x_p) - ones(x_m) over the
// N samples the bench drives inside a window.
module tb_stoch_vec_decoder;
    localparam int VL = 2;
    localparam int WL = 4;
    localparam int N  = 1 << WL;
    localparam int YW = WL + 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            start = 1'b0;
    logic            y_ready = 1'b0;
    logic [VL-1:0]   x_p = '0;
    logic [VL-1:0]   x_m = '0;
    logic            busy, y_valid;
    logic [VL*YW-1:0] y;
`ifdef STOCH_VEC_DECODER_CONT_EN
    logic            overrun;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_y [VL];

    always #5 CLK = ~CLK;

    stoch_vec_decoder #(.VEC_LEN(VL), .WIN_LOG2(WL)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .busy    (busy),
        .x_p     (x_p),
        .x_m     (x_m),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
`ifdef STOCH_VEC_DECODER_CONT_EN
        ,
        .overrun (overrun)
`endif
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int lane(input int i);
        return int'($signed(y[i*YW +: YW]));
    endfunction

    task automatic chk_lanes(input string tag);
        for (int i = 0; i < VL; i++) chk($sformatf("%s_lane%0d", tag, i), lane(i), exp_y[i]);
    endtask

    // Drive one sample for the coming edge and account for it in the model
    task automatic drive_x(input int pat, input int k);
        for (int i = 0; i < VL; i++) begin
            case (pat)
                0: begin x_p[i] = 1'b1; x_m[i] = 1'b0; end
                1: begin x_p[i] = (i == 0); x_m[i] = 1'b1; end
                2: begin
                    if (i == 0) begin x_p[i] = (k % 2 == 0); x_m[i] = 1'b0; end
                    else begin x_p[i] = 1'($urandom_range(0, 1)); x_m[i] = 1'($urandom_range(0, 1)); end
                end
                default: begin x_p[i] = 1'($urandom_range(0, 1)); x_m[i] = 1'($urandom_range(0, 1)); end
            endcase
            exp_y[i] += int'(x_p[i]) - int'(x_m[i]);
        end
    endtask

    task automatic rand_x();
        x_p = VL'($urandom);
        x_m = VL'($urandom);
    endtask

    // N sample edges; caller is just after the edge that opened the window
    task automatic accumulate(input int pat, input bit noisy, input bit early_chk);
        for (int i = 0; i < VL; i++) exp_y[i] = 0;
        for (int k = 0; k < N; k++) begin
            drive_x(pat, k);
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (k == N - 2 && early_chk) chk("valid_early", y_valid, 0);
        end
        start = 1'b0;
        chk("valid_done", y_valid, 1);
        chk_lanes("result");
    endtask

`ifndef STOCH_VEC_DECODER_CONT_EN
    task automatic launch();
        start = 1'b1;
        rand_x();
        tick();
        start = 1'b0;
        chk("busy_start", busy, 1);
    endtask

    task automatic hold(input int cycles);
        y_ready = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            start = 1'($urandom_range(0, 1));
            rand_x();
            tick();
            chk("hold_valid", y_valid, 1);
            chk("hold_busy", busy, 0);
            chk_lanes("hold");
        end
        start = 1'b0;
    endtask

    task automatic release_y(input bit b2b);
        y_ready = 1'b1;
        start   = b2b;
        rand_x();
        tick();
        y_ready = 1'b0;
        start   = 1'b0;
        chk("valid_drop", y_valid, 0);
        chk("busy_b2b", busy, int'(b2b));
    endtask

    task automatic idle_retain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            start = 1'b0;
            y_ready = 1'($urandom_range(0, 1));
            rand_x();
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_valid", y_valid, 0);
            chk_lanes("retain");
        end
        y_ready = 1'b0;
    endtask
`endif

    initial begin
        RST = 1'b1;
        tick();
        tick();
        for (int i = 0; i < VL; i++) exp_y[i] = 0;
        chk("rst_valid", y_valid, 0);
        chk_lanes("rst_y");
`ifdef STOCH_VEC_DECODER_CONT_EN
        chk("rst_overrun", overrun, 0);
        // Free-running, consumer stalled: second completion overruns
        y_ready = 1'b0;
        RST = 1'b0;
        accumulate(3, 1'b1, 1'b1);
        chk("ovr_first", overrun, 0);
        chk("busy_cont", busy, 1);
        accumulate(3, 1'b1, 1'b0);
        chk("ovr_second", overrun, 1);
        #3 RST = 1'b1;
        #1 chk("ovr_clear", overrun, 0);
        tick();
        // Consumer always ready: every result fresh, never an overrun
        y_ready = 1'b1;
        RST = 1'b0;
        for (int w = 0; w < 3; w++) begin
            accumulate(3, 1'b1, 1'b1);
            chk("ovr_ready", overrun, 0);
        end
`else
        chk("rst_busy", busy, 0);
        RST = 1'b0;
        tick();
        // y_ready with nothing valid does nothing
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk("idle_ready", y_valid, 0);

        // All ones on x_p: +N per lane
        launch();
        accumulate(0, 1'b0, 1'b1);
        chk("busy_done", busy, 0);
        release_y(1'b0);

        // Cancelling pair on lane0, all-negative on lane1
        launch();
        accumulate(1, 1'b0, 1'b1);
        release_y(1'b0);

        // Alternating lane0, long stall, then return to idle with y retained
        launch();
        accumulate(2, 1'b0, 1'b1);
        hold(10);
        release_y(1'b0);
        idle_retain(3);

        // Back-to-back windows with stray start pulses mid-window
        launch();
        accumulate(3, 1'b1, 1'b1);
        release_y(1'b1);
        accumulate(3, 1'b1, 1'b1);
        release_y(1'b0);

        // Abort a window partway with async reset
        launch();
        for (int k = 0; k < 7; k++) begin
            drive_x(3, k);
            tick();
        end
        #3 RST = 1'b1;
        #1;
        for (int i = 0; i < VL; i++) exp_y[i] = 0;
        chk("abort_valid", y_valid, 0);
        chk("abort_busy", busy, 0);
        chk_lanes("abort_y");
        tick();
        RST = 1'b0;
        tick();
        launch();
        accumulate(3, 1'b0, 1'b1);
        release_y(1'b0);

        // Randomized windows, stalls and back-to-back mixes
        for (int w = 0; w < 6; w++) begin
            launch();
            accumulate(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            hold(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) begin
                release_y(1'b1);
                accumulate(3, 1'b1, 1'b1);
            end
            release_y(1'b0);
            idle_retain(int'($urandom_range(0, 2)));
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
